// File: rtl/ahb_arb_pkg.sv
// Shared encodings, FSM state type and burst-length helper for the AHB-Lite bus arbiter.
package ahb_arb_pkg;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransBusy   = 2'b01;
    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;

    localparam logic [2:0] HburstSingle = 3'b000;
    localparam logic [2:0] HburstIncr   = 3'b001;
    localparam logic [2:0] HburstWrap4  = 3'b010;
    localparam logic [2:0] HburstIncr4  = 3'b011;
    localparam logic [2:0] HburstWrap8  = 3'b100;
    localparam logic [2:0] HburstIncr8  = 3'b101;
    localparam logic [2:0] HburstWrap16 = 3'b110;
    localparam logic [2:0] HburstIncr16 = 3'b111;

    localparam logic [1:0] HrespOkay  = 2'b00;
    localparam logic [1:0] HrespError = 2'b01;

    typedef enum logic [1:0] {
        StPark,
        StOwn,
        StBurst,
        StLock
    } arb_state_e;

    // Remaining beats after the NONSEQ beat of a fixed-length burst; 0 for SINGLE/INCR.
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        logic [3:0] beats;
        case (hburst)
            HburstWrap4, HburstIncr4:   beats = 4'd3;
            HburstWrap8, HburstIncr8:   beats = 4'd7;
            HburstWrap16, HburstIncr16: beats = 4'd15;
            default:                    beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin search: first requester after ptr_i, wrapping; ptr_i itself is last.
module ahb_rr_picker #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned MID_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [MID_W-1:0]       ptr_i,
    output logic                   found_o,
    output logic [MID_W-1:0]       winner_o
);

    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
                if (!found_o && req_i[j] && (j == (32'(ptr_i) + i) % NUM_MASTERS)) begin
                    found_o  = 1'b1;
                    winner_o = MID_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Burst- and lock-aware round-robin AHB-Lite arbiter driving address/data-phase owner selects.
// Optional AHB_ARB_ERR_ABORT_EN: an ERROR response aborts the burst/lock and forces arbitration.
module ahb_bus_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned MID_W          = 2,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MID_W-1:0]       HMASTER,
    output logic [MID_W-1:0]       HMASTER_D,
    output logic                   HMASTLOCK
);

    localparam logic [MID_W-1:0] DefIdx = MID_W'(DEFAULT_MASTER);

    arb_state_e       state_q, state_d;
    logic [MID_W-1:0] owner_q, owner_d;
    logic [MID_W-1:0] hmaster_q, hmaster_d;
    logic [MID_W-1:0] hmaster_dp_q, hmaster_dp_d;
    logic             mastlock_q, mastlock_d;
    logic             lock_tail_q, lock_tail_d;
    logic [3:0]       beat_cnt_q, beat_cnt_d;
    logic [MID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             err_pend_q, err_pend_d;

    logic [NUM_MASTERS-1:0] owner_oh, winner_oh;
    logic                   owner_req, owner_lock, others_req;
    logic                   trans_idle, in_incr, start_fixed, handover_pend;
    logic                   err_first, arb_ok;
    logic                   rr_found;
    logic [MID_W-1:0]       rr_winner;

    ahb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .MID_W       (MID_W)
    ) u_picker (
        .req_i    (HBUSREQ),
        .ptr_i    (rr_ptr_q),
        .found_o  (rr_found),
        .winner_o (rr_winner)
    );

`ifdef AHB_ARB_ERR_ABORT_EN
    assign err_first = (HRESP == HrespError) && !HREADY;
`else
    logic unused_resp;
    assign unused_resp = ^HRESP;
    assign err_first   = 1'b0;
`endif

    assign owner_oh      = NUM_MASTERS'(1) << owner_q;
    assign winner_oh     = NUM_MASTERS'(1) << rr_winner;
    assign owner_req     = |(HBUSREQ & owner_oh);
    assign owner_lock    = |(HLOCK & owner_oh);
    assign others_req    = |(HBUSREQ & ~owner_oh);
    assign trans_idle    = (HTRANS == HtransIdle);
    assign in_incr       = (HBURST == HburstIncr) && !trans_idle;
    assign start_fixed   = (HTRANS == HtransNonseq) && (burst_beats(HBURST) != 4'd0);
    // New grant has not reached the address phase yet; re-arbitrating now would ping-pong.
    assign handover_pend = (hmaster_q != owner_q);

    assign arb_ok = HREADY && (err_pend_q ||
                    (!handover_pend && (beat_cnt_q == 4'd0 || trans_idle) && !start_fixed &&
                     !owner_lock && !mastlock_q && !lock_tail_q &&
                     (!owner_req || trans_idle || (in_incr && others_req))));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        hmaster_d    = hmaster_q;
        hmaster_dp_d = hmaster_dp_q;
        mastlock_d   = mastlock_q;
        lock_tail_d  = lock_tail_q;
        beat_cnt_d   = beat_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        err_pend_d   = err_pend_q;

        if (HREADY) begin
            hmaster_d    = owner_q;
            hmaster_dp_d = hmaster_q;
            mastlock_d   = owner_lock;
            lock_tail_d  = mastlock_q;
            err_pend_d   = 1'b0;
            if (HTRANS == HtransNonseq) begin
                beat_cnt_d = burst_beats(HBURST);
            end else if (HTRANS == HtransSeq && beat_cnt_q != 4'd0) begin
                beat_cnt_d = beat_cnt_q - 4'd1;
            end else if (trans_idle) begin
                beat_cnt_d = 4'd0;
            end

            case (state_q)
                StLock: begin
                    if (!owner_lock) state_d = (beat_cnt_d != 4'd0) ? StBurst : StOwn;
                end
                default: begin
                    if (beat_cnt_d != 4'd0)     state_d = StBurst;
                    else if (state_q == StBurst) state_d = StOwn;
                end
            endcase
        end

        if (arb_ok) begin
            if (rr_found) begin
                owner_d  = rr_winner;
                rr_ptr_d = rr_winner;
                state_d  = |(HLOCK & winner_oh) ? StLock : StOwn;
            end else begin
                owner_d = DefIdx;
                state_d = StPark;
            end
        end

        if (err_first) begin
            beat_cnt_d = 4'd0;
            err_pend_d = 1'b1;
            if (state_q == StLock || state_q == StBurst) state_d = StOwn;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= StPark;
            owner_q      <= DefIdx;
            hmaster_q    <= DefIdx;
            hmaster_dp_q <= DefIdx;
            mastlock_q   <= 1'b0;
            lock_tail_q  <= 1'b0;
            beat_cnt_q   <= 4'd0;
            rr_ptr_q     <= DefIdx;
            err_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            hmaster_q    <= hmaster_d;
            hmaster_dp_q <= hmaster_dp_d;
            mastlock_q   <= mastlock_d;
            lock_tail_q  <= lock_tail_d;
            beat_cnt_q   <= beat_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            err_pend_q   <= err_pend_d;
        end
    end

    assign HGRANT    = owner_oh;
    assign HMASTER   = hmaster_q;
    assign HMASTER_D = hmaster_dp_q;
    assign HMASTLOCK = mastlock_q;

endmodule
